// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, control-bit positions and FSM state type for the sequential ALU.
package alu_seq_pkg;

  localparam logic [2:0] ALU_ADD_SUB = 3'd0;
  localparam logic [2:0] ALU_SLL     = 3'd1;
  localparam logic [2:0] ALU_SLT     = 3'd2;
  localparam logic [2:0] ALU_SLTU    = 3'd3;
  localparam logic [2:0] ALU_XOR     = 3'd4;
  localparam logic [2:0] ALU_SRL_SRA = 3'd5;
  localparam logic [2:0] ALU_OR      = 3'd6;
  localparam logic [2:0] ALU_AND     = 3'd7;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam int unsigned FN_MD   = 5;
  localparam int unsigned FN_WORD = 4;
  localparam int unsigned FN_ALT  = 3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Callers truncate to XLEN, so this also serves XLEN=32.
  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative M-extension unit: MSB-first shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with the sign applied as the last iteration completes.
module muldiv_iter
  import alu_seq_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic            word,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  logic              run_q, neg_q, word_q;
  logic [2:0]        op_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [2*XLEN-1:0] acc_q, acc_nx, prod;
  logic [XLEN:0]     rs;
  logic [XLEN-1:0]   rd, qr;
  logic              ge;
  logic              sign_a, sign_b, signed_a, signed_b, start_neg;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic neg,
                                          input logic w);
    logic [XLEN-1:0] t;
    t = neg ? -x : x;
    return w ? XLEN'(t[31:0]) : t;
  endfunction

  always_comb begin
    sign_a   = word ? operand_a[31] : operand_a[XLEN-1];
    sign_b   = word ? operand_b[31] : operand_b[XLEN-1];
    signed_a = funct3[2] ? !funct3[0] : (funct3 != MD_MULHU);
    signed_b = funct3[2] ? !funct3[0] : (funct3 == MD_MUL || funct3 == MD_MULH);
    // Remainder follows the dividend; everything else follows sign(a) ^ sign(b).
    start_neg = (funct3 == MD_REM || funct3 == MD_REMU) ? (signed_a & sign_a)
                                                         : ((signed_a & sign_a) ^ (signed_b & sign_b));
  end

  always_comb begin
    rs = {acc_q[2*XLEN-1:XLEN], a_q[cnt_q]};
    ge = rs >= {1'b0, b_q};
    rd = ge ? XLEN'(rs - {1'b0, b_q}) : rs[XLEN-1:0];
    if (op_q[2]) begin
      acc_nx = {rd, acc_q[XLEN-2:0], ge};
    end else begin
      acc_nx = (acc_q << 1) + (b_q[cnt_q] ? {{XLEN{1'b0}}, a_q} : '0);
    end
  end

  always_comb begin
    prod   = neg_q ? -acc_nx : acc_nx;
    qr     = op_q[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
    qr     = neg_q ? -qr : qr;
    result = '0;
    if (op_q[2]) begin
      result = word_q ? XLEN'(sext32(qr[31:0])) : qr;
    end else if (word_q) begin
      result = XLEN'(sext32(prod[31:0]));
    end else if (op_q == MD_MUL) begin
      result = prod[XLEN-1:0];
    end else begin
      result = prod[2*XLEN-1:XLEN];
    end
  end

  assign done = run_q && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      neg_q  <= 1'b0;
      word_q <= 1'b0;
      op_q   <= '0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else if (flush) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      run_q  <= 1'b1;
      neg_q  <= start_neg;
      word_q <= word;
      op_q   <= funct3;
      cnt_q  <= word ? CW'(31) : CW'(XLEN - 1);
      a_q    <= mag(operand_a, signed_a & sign_a, word);
      b_q    <= mag(operand_b, signed_b & sign_b, word);
      acc_q  <= '0;
    end else if (run_q) begin
      acc_q <= acc_nx;
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU behind a valid/ready handshake: base ops and M special cases finish in one
// registered cycle, general multiply/divide run through the iterative unit.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      alu_function,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            result_lsb,
  output logic            result_eq_zero,
  output logic            busy
);

  localparam int unsigned     SHW     = (XLEN == 64) ? 6 : 5;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] base_full, base_res, special_res, md_result;
  logic [31:0]     a32, b32, base_w;
  logic [SHW-1:0]  shamt;
  logic [2:0]      funct3;
  logic            word, alt, is_md, b_zero, ovf, md_special, quick, accept, md_start, md_done;

  assign funct3 = alu_function[2:0];
  assign word   = (XLEN == 64) && alu_function[FN_WORD];
  assign alt    = alu_function[FN_ALT];
  assign is_md  = alu_function[FN_MD];
  assign a32    = operand_a[31:0];
  assign b32    = operand_b[31:0];
  assign shamt  = operand_b[SHW-1:0];

  always_comb begin
    base_full = '0;
    base_w    = '0;
    case (funct3)
      ALU_ADD_SUB: begin
        base_full = alt ? operand_a - operand_b : operand_a + operand_b;
        base_w    = alt ? a32 - b32 : a32 + b32;
      end
      ALU_SLL: begin
        base_full = operand_a << shamt;
        base_w    = a32 << b32[4:0];
      end
      ALU_SLT: begin
        base_full = XLEN'($signed(operand_a) < $signed(operand_b));
        base_w    = 32'($signed(a32) < $signed(b32));
      end
      ALU_SLTU: begin
        base_full = XLEN'(operand_a < operand_b);
        base_w    = 32'(a32 < b32);
      end
      ALU_XOR: begin
        base_full = operand_a ^ operand_b;
        base_w    = a32 ^ b32;
      end
      ALU_SRL_SRA: begin
        // Kept as if/else: a ternary would make the signed shift unsigned.
        if (alt) begin
          base_full = $signed(operand_a) >>> shamt;
          base_w    = $signed(a32) >>> b32[4:0];
        end else begin
          base_full = operand_a >> shamt;
          base_w    = a32 >> b32[4:0];
        end
      end
      ALU_OR: begin
        base_full = operand_a | operand_b;
        base_w    = a32 | b32;
      end
      default: begin
        base_full = operand_a & operand_b;
        base_w    = a32 & b32;
      end
    endcase
    base_res = word ? XLEN'(sext32(base_w)) : base_full;
  end

  always_comb begin
    b_zero = word ? (b32 == '0) : (operand_b == '0);
    ovf    = !funct3[0] && (word ? (a32 == 32'h8000_0000 && b32 == '1)
                                 : (operand_a == MIN_VAL && operand_b == '1));
    md_special  = funct3[2] && (b_zero || ovf);
    special_res = '0;
    if (b_zero) begin
      special_res = funct3[1] ? (word ? XLEN'(sext32(a32)) : operand_a) : '1;
    end else if (!funct3[1]) begin
      special_res = word ? XLEN'(sext32(32'h8000_0000)) : MIN_VAL;
    end
  end

  assign accept   = in_valid && (state_q == IDLE) && !flush;
  assign quick    = !is_md || !ENABLE_M || md_special;
  assign md_start = accept && !quick;

  if (ENABLE_M) begin : g_md
    muldiv_iter #(
      .XLEN(XLEN)
    ) u_muldiv (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .start     (md_start),
      .word      (word),
      .funct3    (funct3),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .done      (md_done),
      .result    (md_result)
    );
  end else begin : g_no_md
    assign md_done   = 1'b0;
    assign md_result = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = quick ? DONE : BUSY;
      BUSY:    if (md_done) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;

    result_d = result_q;
    if (accept && quick) begin
      result_d = !is_md ? base_res : (ENABLE_M ? special_res : '0);
    end else if (state_q == BUSY && md_done && !flush) begin
      result_d = md_result;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign result         = result_q;
  assign result_lsb     = result_q[0];
  assign result_eq_zero = (result_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (XLEN=64): expected results are queued at issue and compared
// when out_valid appears, along with the issue-to-valid latency.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [5:0]  alu_function = '0;
  logic [63:0] operand_a = '0;
  logic [63:0] operand_b = '0;
  logic        in_ready, out_valid, result_lsb, result_eq_zero, busy;
  logic [63:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  alu_seq #(
    .XLEN     (64),
    .ENABLE_M (1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_function   (alu_function),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .result_lsb     (result_lsb),
    .result_eq_zero (result_eq_zero),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] fn, input logic [63:0] a, input logic [63:0] b,
                       input bit push, input logic [63:0] exp);
    @(negedge clk);
    alu_function = fn;
    operand_a    = a;
    operand_b    = b;
    in_valid     = 1'b1;
    if (push) exp_q.push_back(exp);
  endtask

  // Counts edges from issue until out_valid, scrambling operands right after acceptance.
  task automatic wait_out(input string tag, input int exp_lat);
    int          lat;
    logic [63:0] want;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        in_valid  = 1'b0;
        operand_a = {$urandom, $urandom};
        operand_b = {$urandom, $urandom};
      end
    end while (!out_valid && lat < 200);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    chk({tag, " result"}, result, want);
    chk({tag, " eq_zero"}, 64'(result_eq_zero), 64'(want == 64'd0));
    chk({tag, " lsb"}, 64'(result_lsb), 64'(want[0]));
  endtask

  task automatic run_op(input string tag, input logic [5:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    issue(fn, a, b, 1'b1, exp);
    wait_out(tag, exp_lat);
    @(posedge clk);
    #1;
    chk({tag, " back to idle"}, {62'd0, in_ready, busy}, 64'b10);
  endtask

  initial begin
    int seen;

    #1;
    chk("reset outputs", {result, 60'd0, out_valid, busy, in_ready, result_eq_zero}, {64'd0, 64'h3});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("ADD",  6'b000000, 64'd5, 64'd7, 64'd12, 1);
    run_op("SUB",  6'b001000, 64'd7, 64'd7, 64'd0, 1);
    run_op("SRAW", 6'b011101, 64'h0000_0000_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 1);
    run_op("SLT",  6'b000010, '1, 64'd1, 64'd1, 1);
    run_op("SLTU", 6'b000011, '1, 64'd1, 64'd0, 1);
    run_op("SRL",  6'b000101, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1);
    run_op("MULHU", 6'b100011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("MULW",  6'b110000, 64'h1_0000, 64'h1_0000, 64'd0, 33);
    run_op("MUL",   6'b100000, -64'sd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 65);
    run_op("DIV",   6'b100100, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("REM",   6'b100110, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("DIVUW", 6'b110101, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'd14, 33);
    run_op("DIV0",  6'b100100, 64'd5, 64'd0, '1, 1);
    run_op("REMU0", 6'b100111, 64'd5, 64'd0, 64'd5, 1);
    run_op("DIVOVF", 6'b100100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run_op("REMOVF", 6'b100110, 64'h8000_0000_0000_0000, '1, 64'd0, 1);

    // Backpressure: result held in DONE, new offers ignored.
    out_ready = 1'b0;
    issue(6'b100101, 64'd100, 64'd7, 1'b1, 64'd14);
    wait_out("DIVU bp", 65);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      alu_function = 6'b000000;
      operand_a    = 64'd1;
      operand_b    = 64'd1;
      in_valid     = 1'b1;
      @(posedge clk);
      #1;
      chk("bp hold", {result, 62'd0, out_valid, in_ready}, {64'd14, 64'b10});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp release", {62'd0, out_valid, busy}, 64'd0);
    @(posedge clk);
    #1;
    chk("bp no accept", {62'd0, out_valid, busy}, 64'd0);

    // Flush in the tenth cycle of a divide.
    issue(6'b100100, 64'd1000, 64'd3, 1'b0, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush idle", {61'd0, out_valid, busy, in_ready}, 64'b001);
    seen = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("flush no out_valid", 64'(seen), 64'd0);

    // Flush together with an offer: nothing accepted.
    issue(6'b000000, 64'd2, 64'd2, 1'b0, 64'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush+valid", {62'd0, out_valid, busy}, 64'd0);
    run_op("ADD after flush", 6'b000000, 64'd1, 64'd2, 64'd3, 1);

    // Asynchronous reset in the middle of a multiply.
    issue(6'b100000, 64'd3, 64'd5, 1'b0, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset mid-MUL", {result, 60'd0, out_valid, busy, in_ready, result_eq_zero},
        {64'd0, 64'h3});
    @(negedge clk);
    rst_n = 1'b1;
    run_op("MUL after reset", 6'b100000, 64'd6, 64'd7, 64'd42, 65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
